// File: rtl/companion_action_scheduler.sv
// Sole writer of the companion stats: arbitrates user care actions against decay ticks
// and runs the exec/exec_status handshake with the external action executor.
module companion_action_scheduler #(
  parameter int CLOCK_FREQ   = 125_000_000,
  parameter int EXEC_TIMEOUT = CLOCK_FREQ * 2,
  parameter int STAT_MAX     = 100,
  parameter int ACTION_GAIN  = 10,
  parameter int DECAY_STEP   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        action_req,
  input  logic [1:0]  action_sel,
  input  logic        decay_tick,
  input  logic        exec_status,
  output logic        exec,
  output logic [1:0]  active_sel,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] happiness,
  output logic [31:0] hunger,
  output logic [31:0] health,
  output logic [31:0] clean
);

  typedef enum logic [2:0] {IDLE, DECAY, EXEC, RELEASE, APPLY} state_t;

  localparam int TW = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [TW-1:0]      TMR_LAST = TW'(EXEC_TIMEOUT - 1);
  localparam logic signed [32:0] SMAX     = 33'(STAT_MAX);
  localparam logic signed [32:0] GAIN     = 33'(ACTION_GAIN);
  localparam logic signed [32:0] DSTEP    = 33'(DECAY_STEP);
  localparam logic signed [32:0] DSTEP2   = 33'(2 * DECAY_STEP);
  localparam logic [31:0]        SMAX32   = 32'(STAT_MAX);

  state_t        state;
  logic [2:0]    decay_cnt;
  logic          pend_valid;
  logic [1:0]    pend_sel;
  logic [TW-1:0] tmr;

  logic          decay_go;
  logic          consume_direct;
  logic [31:0]   dcy_hap, dcy_hun, dcy_hea, dcy_cln;
  logic [31:0]   act_hap, act_hun, act_hea, act_cln;

  function automatic logic signed [32:0] ext(input logic [31:0] s);
    return $signed({1'b0, s});
  endfunction

  function automatic logic [31:0] sat(input logic signed [32:0] v);
    logic [31:0] r;
    if (v < 33'sd0)
      r = '0;
    else if (v > SMAX)
      r = SMAX32;
    else
      r = v[31:0];
    return r;
  endfunction

  assign exec = (state == EXEC);
  assign busy = (state != IDLE);

  assign decay_go       = (decay_cnt != 3'd0) || decay_tick;
  assign consume_direct = (state == IDLE) && !decay_go && !pend_valid && action_req;

  always_comb begin
    dcy_hap = sat(ext(happiness) - DSTEP);
    dcy_hun = sat(ext(hunger) + DSTEP);
    dcy_cln = sat(ext(clean) - DSTEP);
    // Starving or filthy companions lose health twice as fast.
    dcy_hea = sat(ext(health) - (((hunger == SMAX32) || (clean == 32'd0)) ? DSTEP2 : DSTEP));

    act_hap = happiness;
    act_hun = hunger;
    act_hea = health;
    act_cln = clean;
    case (active_sel)
      2'd0: act_hun = sat(ext(hunger) - GAIN);
      2'd1: begin
        act_hap = sat(ext(happiness) + GAIN);
        act_hun = sat(ext(hunger) + DSTEP);
      end
      2'd2: act_hea = sat(ext(health) + GAIN);
      default: act_cln = SMAX32;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      decay_cnt   <= 3'd0;
      pend_valid  <= 1'b0;
      pend_sel    <= 2'd0;
      tmr         <= '0;
      active_sel  <= 2'd0;
      timeout_err <= 1'b0;
      happiness   <= SMAX32;
      hunger      <= 32'd0;
      health      <= SMAX32;
      clean       <= SMAX32;
    end else begin
      timeout_err <= 1'b0;

      // A tick coinciding with a DECAY cycle cancels out.
      if (decay_tick && (state != DECAY)) begin
        if (decay_cnt != 3'd7)
          decay_cnt <= decay_cnt + 3'd1;
      end else if (!decay_tick && (state == DECAY)) begin
        decay_cnt <= decay_cnt - 3'd1;
      end

      if (action_req && !pend_valid && !consume_direct) begin
        pend_valid <= 1'b1;
        pend_sel   <= action_sel;
      end

      case (state)
        IDLE: begin
          if (decay_go) begin
            state <= DECAY;
          end else if (pend_valid || action_req) begin
            state      <= EXEC;
            active_sel <= pend_valid ? pend_sel : action_sel;
            pend_valid <= 1'b0;
            tmr        <= '0;
          end
        end
        DECAY: begin
          happiness <= dcy_hap;
          hunger    <= dcy_hun;
          health    <= dcy_hea;
          clean     <= dcy_cln;
          state     <= IDLE;
        end
        EXEC, RELEASE: begin
          if (tmr == TMR_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
            if ((state == EXEC) && exec_status)
              state <= RELEASE;
            else if ((state == RELEASE) && !exec_status)
              state <= APPLY;
          end
        end
        APPLY: begin
          happiness <= act_hap;
          hunger    <= act_hun;
          health    <= act_hea;
          clean     <= act_cln;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_companion_action_scheduler.sv
// Bench for companion_action_scheduler: vector table, hand-written handshake corner cases,
// and random action/decay traffic checked against a stat-level reference model.
module tb_companion_action_scheduler;

  localparam int STAT_MAX = 100;
  localparam int GAIN     = 10;
  localparam int DSTEP    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        action_req = 1'b0;
  logic [1:0]  action_sel = 2'd0;
  logic        decay_tick = 1'b0;
  logic        exec_status = 1'b0;
  logic        exec;
  logic [1:0]  active_sel;
  logic        busy;
  logic        timeout_err;
  logic [31:0] happiness, hunger, health, clean;

  always #5 clk = ~clk;

  companion_action_scheduler #(.EXEC_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .action_req(action_req), .action_sel(action_sel),
    .decay_tick(decay_tick), .exec_status(exec_status), .exec(exec),
    .active_sel(active_sel), .busy(busy), .timeout_err(timeout_err),
    .happiness(happiness), .hunger(hunger), .health(health), .clean(clean)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int m_hap, m_hun, m_hea, m_cln;

  typedef struct {
    int kind;  // 0 = burst of decay ticks, 1 = care action
    int arg;   // tick count or action select
    int hap, hun, hea, cln;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input int h, input int u, input int e, input int c);
    check({tag, ".happiness"}, happiness, h);
    check({tag, ".hunger"}, hunger, u);
    check({tag, ".health"}, health, e);
    check({tag, ".clean"}, clean, c);
  endtask

  function automatic int clampv(input int v);
    return (v < 0) ? 0 : ((v > STAT_MAX) ? STAT_MAX : v);
  endfunction

  task automatic model_decay();
    int loss;
    loss = ((m_hun == STAT_MAX) || (m_cln == 0)) ? 2 * DSTEP : DSTEP;
    m_hea = clampv(m_hea - loss);
    m_hap = clampv(m_hap - DSTEP);
    m_hun = clampv(m_hun + DSTEP);
    m_cln = clampv(m_cln - DSTEP);
  endtask

  task automatic model_action(input int sel);
    case (sel)
      0: m_hun = clampv(m_hun - GAIN);
      1: begin m_hap = clampv(m_hap + GAIN); m_hun = clampv(m_hun + DSTEP); end
      2: m_hea = clampv(m_hea + GAIN);
      default: m_cln = STAT_MAX;
    endcase
  endtask

  task automatic wait_exec(input logic val, input string name);
    int i = 0;
    while (exec !== val && i < 30) begin step(); i++; end
    check(name, exec, val);
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (busy !== 1'b0 && i < 30) begin step(); i++; end
    check(name, busy, 0);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin decay_tick = 1'b1; step(); decay_tick = 1'b0; end
    repeat (2 * n + 4) step();
  endtask

  task automatic run_action(input int sel, input int d1, input int d2, input int nt);
    action_sel = 2'(sel);
    action_req = 1'b1;
    step();
    action_req = 1'b0;
    wait_exec(1'b1, "act.exec_rise");
    check("act.active_sel", active_sel, sel);
    repeat (nt) begin decay_tick = 1'b1; step(); decay_tick = 1'b0; end
    repeat (d1) step();
    exec_status = 1'b1;
    wait_exec(1'b0, "act.exec_fall");
    repeat (d2) step();
    exec_status = 1'b0;
    wait_idle("act.busy_fall");
    repeat (2 * nt + 4) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt_a, cnt_b;

    tbl[0] = '{0, 5,  95, 5,  95,  95};
    tbl[1] = '{1, 0,  95, 0,  95,  95};
    tbl[2] = '{1, 1, 100, 1,  95,  95};
    tbl[3] = '{1, 2, 100, 1, 100,  95};
    tbl[4] = '{0, 5,  95, 6,  95,  90};
    tbl[5] = '{1, 3,  95, 6,  95, 100};
    tbl[6] = '{1, 2,  95, 6, 100, 100};
    tbl[7] = '{0, 3,  92, 9,  97,  97};

    // Reset values while reset is held
    repeat (2) step();
    check("rst.exec", exec, 0);
    check("rst.busy", busy, 0);
    check("rst.timeout_err", timeout_err, 0);
    check("rst.active_sel", active_sel, 0);
    check_stats("rst", 100, 0, 100, 100);
    rst = 1'b1;
    step();

    // Feed with hunger already 0: ack after 3 cycles, release after 5
    action_sel = 2'd0;
    action_req = 1'b1;
    step();
    action_req = 1'b0;
    check("feed.exec_k1", exec, 1);
    check("feed.busy_k1", busy, 1);
    step();
    step();
    check("feed.exec_held", exec, 1);
    exec_status = 1'b1;
    step();
    check("feed.exec_drop", exec, 0);
    step();
    exec_status = 1'b0;
    step();
    check("feed.busy_apply", busy, 1);
    step();
    check("feed.busy_fall", busy, 0);
    check_stats("feed", 100, 0, 100, 100);

    // Table of action / decay vectors
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].kind == 0) run_ticks(tbl[i].arg);
      else run_action(tbl[i].arg, 1, 1, 0);
      check_stats($sformatf("tbl%0d", i), tbl[i].hap, tbl[i].hun, tbl[i].hea, tbl[i].cln);
    end

    // Async reset during RELEASE with a pending wash queued
    action_sel = 2'd0;
    action_req = 1'b1;
    step();
    action_sel = 2'd3;
    step();
    action_req = 1'b0;
    exec_status = 1'b1;
    step();
    check("rrel.busy_release", busy, 1);
    check("rrel.exec_release", exec, 0);
    #2 rst = 1'b0;
    #1;
    check("rrel.exec", exec, 0);
    check("rrel.busy", busy, 0);
    check_stats("rrel", 100, 0, 100, 100);
    #2 rst = 1'b1;
    exec_status = 1'b0;
    cnt_a = 0;
    repeat (8) begin step(); if (exec) cnt_a++; end
    check("rrel.pend_empty", cnt_a, 0);

    // Nine ticks while the handshake stalls: counter saturates at 7
    action_sel = 2'd2;
    action_req = 1'b1;
    step();
    action_req = 1'b0;
    wait_exec(1'b1, "sat.exec_rise");
    repeat (9) begin decay_tick = 1'b1; step(); decay_tick = 1'b0; end
    step();
    exec_status = 1'b1;
    wait_exec(1'b0, "sat.exec_fall");
    step();
    exec_status = 1'b0;
    wait_idle("sat.busy_fall");
    cnt_a = 0;
    repeat (30) begin step(); if (busy) cnt_a++; end
    check("sat.decay_runs", cnt_a, 7);
    check_stats("sat", 93, 7, 93, 93);

    // Tick and wash in the same IDLE cycle; second request during EXEC dropped
    decay_tick = 1'b1;
    action_req = 1'b1;
    action_sel = 2'd3;
    step();
    decay_tick = 1'b0;
    action_req = 1'b0;
    check("coin.decay_busy", busy, 1);
    check("coin.decay_exec", exec, 0);
    step();
    check("coin.idle_busy", busy, 0);
    step();
    check("coin.exec", exec, 1);
    check("coin.active_sel", active_sel, 3);
    action_req = 1'b1;
    action_sel = 2'd1;
    step();
    action_sel = 2'd2;
    step();
    action_req = 1'b0;
    exec_status = 1'b1;
    wait_exec(1'b0, "coin.exec_fall");
    exec_status = 1'b0;
    wait_idle("coin.busy_fall");
    check_stats("coin.wash", 92, 8, 92, 100);
    wait_exec(1'b1, "coin.pend_exec");
    check("coin.pend_sel", active_sel, 1);
    exec_status = 1'b1;
    wait_exec(1'b0, "coin.pend_fall");
    exec_status = 1'b0;
    wait_idle("coin.pend_idle");
    check_stats("coin.play", 100, 9, 92, 100);
    cnt_a = 0;
    repeat (20) begin step(); if (exec) cnt_a++; end
    check("coin.dropped", cnt_a, 0);

    // Executor never acknowledges
    action_sel = 2'd2;
    action_req = 1'b1;
    step();
    action_req = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
    repeat (40) begin
      if (exec) cnt_a++;
      if (timeout_err) cnt_b++;
      step();
    end
    check("tmo.exec_cycles", cnt_a, 16);
    check("tmo.err_pulses", cnt_b, 1);
    check("tmo.busy", busy, 0);
    check_stats("tmo", 100, 9, 92, 100);

    // Saturation boundaries and doubled health loss
    do_reset();
    repeat (22) run_ticks(5);
    check_stats("bnd.floor", 0, 100, 0, 0);
    run_action(2, 0, 0, 0);
    run_ticks(2);
    check_stats("bnd.double", 0, 100, 6, 0);

    // Random traffic against the reference model
    m_hap = 0; m_hun = 100; m_hea = 6; m_cln = 0;
    for (int r = 0; r < 40; r++) begin
      int op, n, sel;
      op = $urandom_range(1, 0);
      if (op == 0) begin
        n = $urandom_range(6, 1);
        run_ticks(n);
        repeat (n) model_decay();
      end else begin
        sel = $urandom_range(3, 0);
        n = $urandom_range(5, 0);
        run_action(sel, $urandom_range(3, 0), $urandom_range(2, 0), n);
        model_action(sel);
        repeat (n) model_decay();
      end
      check_stats($sformatf("rnd%0d", r), m_hap, m_hun, m_hea, m_cln);
      check($sformatf("rnd%0d.busy", r), busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
